// File: rtl/pixel_readout_pkg.sv
// rtl/pixel_readout_pkg.sv - shared types and constants for the pixel readout path
package pixel_readout_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/pixel_skid_fifo.sv
// rtl/pixel_skid_fifo.sv - two-entry pixel buffer carrying a last flag per entry
module pixel_skid_fifo
    import pixel_readout_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [N-1:0] push_data,
    input  logic         push_last,
    input  logic         pop,
    output logic [N-1:0] head_data,
    output logic         head_last,
    output logic         empty,
    output logic [1:0]   count
);

    logic [N-1:0] data [FIFO_DEPTH];
    logic [1:0]   last;
    logic         wptr;
    logic         rptr;
    logic         do_push;
    logic         do_pop;

    assign do_push   = push && (count != 2'(FIFO_DEPTH));
    assign do_pop    = pop && (count != 2'd0);
    assign empty     = (count == 2'd0);
    assign head_data = data[rptr];
    assign head_last = last[rptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            data[0] <= '0;
            data[1] <= '0;
            last    <= '0;
            wptr    <= 1'b0;
            rptr    <= 1'b0;
            count   <= 2'd0;
        end else begin
            if (do_push) begin
                data[wptr] <= push_data;
                last[wptr] <= push_last;
                wptr       <= ~wptr;
            end
            if (do_pop) begin
                rptr <= ~rptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/pixel_readout.sv
// rtl/pixel_readout.sv - streams a run of pixel-memory words onto a valid/ready output
module pixel_readout
    import pixel_readout_pkg::*;
#(
    parameter int N      = 32,
    parameter int AW     = 16,
    parameter int STRIDE = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW-1:0] pix_count,
    output logic          mem_rd,
    output logic [AW-1:0] mem_addr,
    input  logic [N-1:0]  mem_rdata,
    output logic [N-1:0]  pix_data,
    output logic          pix_valid,
    input  logic          pix_ready,
    output logic          pix_last,
    output logic          busy,
    output logic          done
);

    state_t        state;
    state_t        state_nx;
    logic [AW-1:0] addr;
    logic [AW-1:0] rd_left;
    logic [AW-1:0] acc_cnt;
    logic [AW-1:0] total;
    logic          inflight;
    logic          inflight_last;
    logic [1:0]    fifo_count;
    logic          fifo_empty;
    logic          head_last;
    logic          pop;
    logic [2:0]    occ;
    logic          can_issue;
    logic          last_issue;
    logic          final_pop;
    logic          accept;

    assign accept     = (state == IDLE) && start;
    assign pop        = !fifo_empty && pix_ready;
    // A pop this cycle frees a slot in time for a read issued now.
    assign occ        = {1'b0, fifo_count} + {2'b0, inflight} - {2'b0, pop};
    assign can_issue  = (occ < 3'(FIFO_DEPTH));
    assign last_issue = mem_rd && (rd_left == AW'(1));
    assign final_pop  = (state == DRAIN) && pop && (acc_cnt == total - AW'(1));

    assign mem_addr  = addr;
    assign pix_valid = !fifo_empty;
    assign pix_last  = !fifo_empty && head_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        mem_rd   = 1'b0;
        case (state)
            IDLE: begin
                if (start && (pix_count != '0)) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                busy   = 1'b1;
                mem_rd = can_issue;
                if (can_issue && (rd_left == AW'(1))) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (final_pop) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr          <= '0;
            rd_left       <= '0;
            acc_cnt       <= '0;
            total         <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            done          <= 1'b0;
        end else begin
            done          <= (accept && (pix_count == '0)) || final_pop;
            inflight      <= mem_rd;
            inflight_last <= last_issue;
            if (accept) begin
                addr    <= base_addr;
                rd_left <= pix_count;
                total   <= pix_count;
                acc_cnt <= '0;
            end else begin
                if (mem_rd) begin
                    rd_left <= rd_left - AW'(1);
                    // Keep the final read address on the bus once the run is issued.
                    if (!last_issue) begin
                        addr <= addr + AW'(STRIDE);
                    end
                end
                if (pop) begin
                    acc_cnt <= acc_cnt + AW'(1);
                end
            end
        end
    end

    pixel_skid_fifo #(.N(N)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data (mem_rdata),
        .push_last (inflight_last),
        .pop       (pop),
        .head_data (pix_data),
        .head_last (head_last),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_pixel_readout.sv
// tb/tb_pixel_readout.sv - scoreboard bench for pixel_readout
module tb_pixel_readout;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] base_addr;
    logic [15:0] pix_count;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [31:0] mem_rdata;
    logic [31:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        pix_last;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    logic [32:0] exp_q [$];
    logic [15:0] addr_q [$];

    logic        bp = 1'b0;
    logic [1:0]  bp_idx = 2'd0;
    logic [3:0]  bp_pat = 4'b1001;

    int          out_cnt = 0;
    logic        prev_stall = 1'b0;
    logic [33:0] prev_word = '0;

    always #5 clk = ~clk;

    pixel_readout #(.N(32), .AW(16), .STRIDE(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .pix_count (pix_count),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .pix_data  (pix_data),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_last  (pix_last),
        .busy      (busy),
        .done      (done)
    );

    always @(posedge clk) begin
        mem_rdata <= mem_rd ? {16'h0000, mem_addr} : 32'hDEAD_BEEF;
    end

    always @(posedge clk) begin
        #1;
        if (bp) begin
            pix_ready = bp_pat[bp_idx];
            bp_idx    = bp_idx + 2'd1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        logic        hs;
        logic [32:0] e;
        int          o;
        if (rst) begin
            out_cnt    = 0;
            prev_stall = 1'b0;
        end else begin
            hs = pix_valid && pix_ready;
            if (prev_stall) chk("stable", {pix_valid, pix_last, pix_data}, prev_word);
            if (hs) begin
                if (exp_q.size() == 0) begin
                    chk("extra_pix", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("pix_data", pix_data, e[31:0]);
                    chk("pix_last", pix_last, e[32]);
                end
            end
            if (mem_rd) begin
                if (addr_q.size() == 0) chk("extra_rd", 1, 0);
                else chk("mem_addr", mem_addr, addr_q.pop_front());
            end
            o = out_cnt + int'(mem_rd) - int'(hs);
            if (mem_rd) chk("outstanding", o <= 2, 1);
            out_cnt    = o;
            prev_stall = pix_valid && !pix_ready;
            prev_word  = {pix_valid, pix_last, pix_data};
        end
    end

    task automatic expect_run(input logic [15:0] b, input int c);
        logic [15:0] a;
        for (int i = 0; i < c; i++) begin
            a = b + 16'(i);
            addr_q.push_back(a);
            exp_q.push_back({(i == c - 1), 16'h0000, a});
        end
    endtask

    task automatic go(input logic [15:0] b, input logic [15:0] c);
        start     = 1'b1;
        base_addr = b;
        pix_count = c;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cyc);
        cyc = 0;
        while (cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (done) break;
        end
        if (!done) chk("done_timeout", 0, 1);
        else chk("busy_with_done", busy, 0);
    endtask

    initial begin
        int cyc;
        rst       = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        pix_count = '0;
        pix_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outputs", {mem_rd, mem_addr, pix_valid, pix_data, pix_last, busy, done}, '0);
        @(posedge clk);
        #1 rst = 1'b0;

        // basic stream with exact latencies
        expect_run(16'h0010, 4);
        go(16'h0010, 16'd4);
        @(negedge clk);
        chk("basic_busy_t1", busy, 1);
        chk("basic_rd_t1", {mem_rd, mem_addr}, {1'b1, 16'h0010});
        @(negedge clk);
        chk("basic_valid_t2", pix_valid, 0);
        @(negedge clk);
        chk("basic_valid_t3", {pix_valid, pix_data}, {1'b1, 32'h10});
        wait_done(50, cyc);
        chk("basic_done_lat", cyc, 4);
        chk("basic_q_empty", exp_q.size(), 0);

        // zero count
        go(16'h0050, 16'd0);
        @(negedge clk);
        chk("zero_t1", {done, busy, mem_rd, pix_valid}, 4'b1000);
        @(negedge clk);
        chk("zero_t2", {done, busy, mem_rd, pix_valid}, 4'b0000);

        // backpressure
        @(posedge clk);
        #1;
        bp = 1'b1;
        expect_run(16'h0040, 8);
        go(16'h0040, 16'd8);
        wait_done(200, cyc);
        chk("bp_q_empty", exp_q.size() + addr_q.size(), 0);
        @(posedge clk);
        #1;
        bp = 1'b0;
        pix_ready = 1'b1;

        // address wrap
        expect_run(16'hFFFE, 4);
        go(16'hFFFE, 16'd4);
        wait_done(50, cyc);
        chk("wrap_q_empty", exp_q.size() + addr_q.size(), 0);

        // start while busy is ignored
        expect_run(16'h0100, 6);
        go(16'h0100, 16'd6);
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = 16'h0900;
        pix_count = 16'd3;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(60, cyc);
        chk("busy_start_q_empty", exp_q.size() + addr_q.size(), 0);
        repeat (4) @(negedge clk);
        chk("busy_start_idle", {busy, mem_rd, pix_valid}, 3'b000);

        // mid-run reset, then a fresh run
        expect_run(16'h0700, 16);
        go(16'h0700, 16'd16);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        addr_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_outputs", {mem_rd, mem_addr, pix_valid, pix_data, pix_last, busy, done}, '0);
        @(negedge clk);
        chk("midrst_no_stale", pix_valid, 0);
        expect_run(16'h0300, 5);
        go(16'h0300, 16'd5);
        wait_done(60, cyc);
        chk("midrst_q_empty", exp_q.size() + addr_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pixel_readout.md
# pixel_readout

Streams a rectangular run of words out of pixel memory once the processor has finished writing it, issuing reads on the memory's read port and presenting each pixel on a valid/ready output stream. It is the consuming end of the pixel-memory path: the pipeline's memory stage writes pixels, and this block reads them back for a display or host link. Its read-side interface matches the pixel memory's synchronous read port.

## Interface
Parameters:
- N, 32, pixel/data word width
- AW, 16, pixel-memory address width
- STRIDE, 1, address increment per pixel

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset; synchronous, active-high
- start  in  1  one-cycle request to begin a readout; ignored while busy
- base_addr  in  AW  first address read; sampled with start
- pix_count  in  AW  number of pixels to stream; sampled with start
- mem_rd  out  1  read strobe to pixel memory
- mem_addr  out  AW  read address
- mem_rdata  in  N  read data, valid exactly one cycle after mem_rd
- pix_data  out  N  output pixel
- pix_valid  out  1  pix_data holds a pixel
- pix_ready  in  1  downstream accepts the pixel
- pix_last  out  1  qualifies the final pixel of the run
- busy  out  1  readout in progress
- done  out  1  one-cycle pulse when the run completes

## Operation
- FSM states are IDLE, RUN, and DRAIN.
- IDLE: when start=1, latch base_addr and pix_count. If pix_count=0, pulse done on the next cycle, produce no output, and stay in IDLE. Otherwise go to RUN.
- RUN: issue reads at mem_addr = base + i*STRIDE for i = 0..pix_count-1. Address arithmetic is modulo 2^AW, so it wraps silently past the top of memory.
- Go to DRAIN after the last read has been issued.
- DRAIN: wait until the final pixel is accepted, then pulse done and return to IDLE.
- Buffering is a 2-entry FIFO that receives mem_rdata.
- A read may issue in a cycle only if (occupancy + reads_in_flight − pop_this_cycle) < 2. The FIFO therefore never overflows, and pix_ready may drop at any time with no data loss.
- pix_valid = FIFO not empty. pix_data = FIFO head.
- A handshake is pix_valid & pix_ready. It pops the FIFO.
- pix_last = 1 when the head is pixel number pix_count−1.
- Once pix_valid is high, pix_data and pix_last must stay stable until the handshake.
- start while busy has no effect.
- rst at any point forces IDLE, flushes the FIFO, and discards in-flight reads. The memory's read data on the following cycle is ignored.

## Timing
- Reset values: mem_rd=0, mem_addr=0, pix_valid=0, pix_data=0, pix_last=0, busy=0, done=0.
- Latency, with start sampled at edge t:
  - mem_rd=1 with base address during cycle t+1
  - mem_rdata captured at the end of cycle t+2
  - pix_valid=1 during cycle t+3
- With pix_ready held high, throughput is 1 pixel per cycle after the first.
- busy rises in cycle t+1. It stays high through the cycle in which the last handshake occurs.
- done pulses in the cycle after the last handshake, with busy=0 in that cycle.
- With pix_count=0, done pulses in cycle t+1 and busy never rises.
- A new start is accepted in the same cycle done pulses.
- mem_addr holds its last value when mem_rd=0.

## Structure
- Package pixel_readout_pkg holds:
  - the state enum typedef (IDLE, RUN, DRAIN)
  - the FIFO depth constant (2)
- Sub-module pixel_skid_fifo is a 2-entry, N-bit FIFO with a last flag per entry.
  - Ports: push, push_data, push_last, pop, head_data, head_last, empty, count.
  - It has the same synchronous active-high rst.
- The top level contains the FSM, the address counter, the issue counter, the accept counter, and the in-flight flag.

## Test plan
- Basic stream: base=0x0010, count=4, pix_ready=1, memory word = address. Expect pix_data 0x10,0x11,0x12,0x13 on consecutive cycles starting at t+3, pix_last on 0x13 only, done at the cycle after, busy low with done.
- Backpressure: count=8, pix_ready toggling 1,0,0,1 repeating. Expect all 8 values in order, no duplicates or drops, pix_data stable while valid and not ready, and at most 2 reads outstanding plus buffered at any time.
- Zero count: start with count=0. Expect done in t+1, busy=0, no mem_rd, no pix_valid.
- Wrap-around: AW=16, base=0xFFFE, count=4, STRIDE=1. Expect addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Mid-run reset: count=16, assert rst in cycle t+6. Expect all outputs at reset values the next cycle, and no pix_valid from the stale mem_rdata. A new start then streams correctly from its own base_addr.
- Start while busy: a second start during RUN with a different base. Expect it ignored and the original run completed unchanged.
